// File: rtl/mov_avg_ctrl.sv
// Sequencer for one moving_average datapath: zero-flushes the window BRAM, drains and
// clears the datapath, then feeds samples and forwards only full-window averages.
module mov_avg_ctrl #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 32,
    parameter int WINDOW_LEN = 16,
    parameter int PIPE_LAT   = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_restart,
    input  logic                        i_enable,
    input  logic signed [DIN_WIDTH-1:0] i_src_data,
    input  logic                        i_src_valid,
    output logic                        o_src_ready,
    output logic                        o_ma_rst,
    output logic signed [DIN_WIDTH-1:0] o_ma_din,
    output logic                        o_ma_din_valid,
    input  logic [DOUT_WIDTH-1:0]       i_ma_dout,
    input  logic                        i_ma_dout_valid,
    output logic [DOUT_WIDTH-1:0]       o_avg,
    output logic                        o_avg_valid,
    output logic [2:0]                  o_state,
    output logic                        o_seq_err
);

    localparam int CNT_W   = $clog2(WINDOW_LEN) + 1;
    localparam int DRAIN_W = $clog2(PIPE_LAT + 1) + 1;
    localparam logic [CNT_W-1:0]   LAST_WRITE = CNT_W'(WINDOW_LEN - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT);

    typedef enum logic [2:0] {
        FLUSH = 3'd0,
        DRAIN = 3'd1,
        CLR   = 3'd2,
        FILL  = 3'd3,
        RUN   = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_nextState;
    logic [CNT_W-1:0]            r_flushCnt;
    logic [CNT_W-1:0]            r_fillCnt;
    logic [DRAIN_W-1:0]          r_drainCnt;
    logic                        r_maRst;
    logic signed [DIN_WIDTH-1:0] r_maDin;
    logic                        r_maDinValid;
    logic [DOUT_WIDTH-1:0]       r_avg;
    logic                        r_avgValid;
    logic                        r_seqErr;
    logic                        w_initState;
    logic                        w_lastFill;
    logic                        w_accept;
    logic                        w_forward;

    assign w_initState = (r_state == FLUSH) || (r_state == DRAIN) || (r_state == CLR);
    assign w_lastFill  = (r_fillCnt == LAST_WRITE);
    assign o_src_ready = i_enable && ((r_state == FILL) || (r_state == RUN));
    assign w_accept    = i_src_valid && o_src_ready && !i_restart;
    // The WINDOW_LEN-th datapath output in FILL is the first full-window average.
    assign w_forward   = i_ma_dout_valid && !i_restart &&
                         (((r_state == FILL) && w_lastFill) || (r_state == RUN));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= FLUSH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FLUSH:   if (r_flushCnt == LAST_WRITE) w_nextState = DRAIN;
            DRAIN:   if (r_drainCnt == LAST_DRAIN) w_nextState = CLR;
            CLR:     w_nextState = FILL;
            FILL:    if (i_ma_dout_valid && w_lastFill) w_nextState = RUN;
            RUN:     w_nextState = RUN;
            default: w_nextState = FLUSH;
        endcase
        if (i_restart) begin
            w_nextState = FLUSH;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flushCnt <= '0;
            r_drainCnt <= '0;
            r_fillCnt  <= '0;
        end else if (i_restart) begin
            r_flushCnt <= '0;
            r_drainCnt <= '0;
            r_fillCnt  <= '0;
        end else begin
            r_flushCnt <= ((r_state == FLUSH) && (w_nextState == FLUSH)) ? r_flushCnt + 1'b1 : '0;
            r_drainCnt <= ((r_state == DRAIN) && (w_nextState == DRAIN)) ? r_drainCnt + 1'b1 : '0;
            if (r_state == FILL) begin
                if (i_ma_dout_valid) begin
                    r_fillCnt <= r_fillCnt + 1'b1;
                end
            end else if (r_state != RUN) begin
                r_fillCnt <= '0;
            end
        end
    end

    // Zero writes during FLUSH overwrite whatever the BRAM held; restart drops a same-cycle sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_maRst      <= 1'b0;
            r_maDin      <= '0;
            r_maDinValid <= 1'b0;
        end else begin
            r_maRst <= (w_nextState == CLR);
            if (i_restart) begin
                r_maDin      <= '0;
                r_maDinValid <= 1'b0;
            end else if (r_state == FLUSH) begin
                r_maDin      <= '0;
                r_maDinValid <= 1'b1;
            end else if (w_accept) begin
                r_maDin      <= i_src_data;
                r_maDinValid <= 1'b1;
            end else begin
                r_maDinValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_avg      <= '0;
            r_avgValid <= 1'b0;
            r_seqErr   <= 1'b0;
        end else begin
            r_avgValid <= w_forward;
            if (w_forward) begin
                r_avg <= i_ma_dout;
            end
            if (i_restart) begin
                r_seqErr <= 1'b0;
            end else if (i_ma_dout_valid && w_initState) begin
                r_seqErr <= 1'b1;
            end
        end
    end

    assign o_ma_rst       = r_maRst;
    assign o_ma_din       = r_maDin;
    assign o_ma_din_valid = r_maDinValid;
    assign o_avg          = r_avg;
    assign o_avg_valid    = r_avgValid;
    assign o_state        = r_state;
    assign o_seq_err      = r_seqErr;

endmodule

// File: tb/tb_mov_avg_ctrl.sv
// Bench for mov_avg_ctrl with a behavioural moving_average attached (WINDOW_LEN=4, PIPE_LAT=2);
// full-window averages are predicted at acceptance and matched on avg_valid.
module tb_mov_avg_ctrl;

   localparam int W   = 4;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;
   logic restart;
   logic enable;
   logic srcValid;
   logic signed [31:0] srcData;
   logic srcReady;
   logic maRst;
   logic signed [31:0] maDin;
   logic maDinValid;
   logic [31:0] maDout;
   logic maDoutValid;
   logic [31:0] avg;
   logic avgValid;
   logic [2:0] state;
   logic seqErr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic signed [31:0] value;
      int due;
   } exp_t;
   exp_t sbQ[$];
   logic signed [31:0] sbWin[W];
   logic signed [33:0] sbSum;
   int sbCount = 0;

   logic signed [31:0] dpWin[W];
   int dpPtr;
   logic dpPrimed;
   logic dpGarbage;
   logic injectValid;
   logic pv1, pv2;
   logic signed [31:0] pd1, pd2;
   logic signed [33:0] dpSum;

   always #5 clk = ~clk;

   mov_avg_ctrl #(
      .DIN_WIDTH(32), .DOUT_WIDTH(32), .WINDOW_LEN(W), .PIPE_LAT(LAT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_restart(restart), .i_enable(enable),
      .i_src_data(srcData), .i_src_valid(srcValid), .o_src_ready(srcReady),
      .o_ma_rst(maRst), .o_ma_din(maDin), .o_ma_din_valid(maDinValid),
      .i_ma_dout(maDout), .i_ma_dout_valid(maDoutValid),
      .o_avg(avg), .o_avg_valid(avgValid), .o_state(state), .o_seq_err(seqErr)
   );

   assign maDout = pd2;
   assign maDoutValid = pv2 | injectValid;

   // Datapath model: BRAM window survives rst, ma_rst only rewinds the pointer; it reports
   // averages only after its own ma_rst, with a two-cycle din->dout latency.
   always @(posedge clk) begin
      if (rst) begin
         dpPtr <= 0;
         dpPrimed <= 1'b0;
         pv1 <= 1'b0;
         pv2 <= 1'b0;
         pd1 <= '0;
         pd2 <= '0;
         if (dpGarbage)
            for (int i = 0; i < W; i++) dpWin[i] <= 32'sd1000003 * (i + 1);
      end else begin
         if (restart) dpPrimed <= 1'b0;
         else if (maRst) dpPrimed <= 1'b1;
         pv1 <= 1'b0;
         if (maRst) begin
            dpPtr <= 0;
         end else if (maDinValid) begin
            dpSum = '0;
            for (int i = 0; i < W; i++) dpSum += (i == dpPtr) ? 34'(maDin) : 34'(dpWin[i]);
            dpWin[dpPtr] <= maDin;
            dpPtr <= (dpPtr + 1) % W;
            pd1 <= 32'((dpSum + 34'sd2) >>> 2);
            pv1 <= dpPrimed;
         end
         pv2 <= pv1;
         pd2 <= pd1;
      end
   end

   // Expected averages: the flushed window starts at zero, rounding is to nearest (half up).
   always @(posedge clk) begin
      if (rst || restart) begin
         sbQ.delete();
         sbCount = 0;
         for (int i = 0; i < W; i++) sbWin[i] = '0;
      end else if (srcValid && srcReady) begin
         for (int i = 0; i < W - 1; i++) sbWin[i] = sbWin[i + 1];
         sbWin[W - 1] = srcData;
         sbCount++;
         if (sbCount >= W) begin
            sbSum = '0;
            for (int i = 0; i < W; i++) sbSum += 34'(sbWin[i]);
            sbQ.push_back('{value: 32'((sbSum + 34'sd2) >>> 2), due: cyc + LAT + 2});
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (avgValid) begin
         checks++;
         assert (sbQ.size() != 0) else begin
            errors++;
            $error("FAIL avg_unexpected observed=%0d expected=none", $signed(avg));
         end
         if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("avg_value", avg, e.value);
            checkOutput("avg_latency", cyc, e.due);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
      end
   endtask

   task automatic applyStimulus(input logic signed [31:0] d);
      srcData = d;
      srcValid = 1'b1;
      #1;
      for (int n = 0; n < 50 && !srcReady; n++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("src_ready_timeout", srcReady, 1);
      @(negedge clk);
      srcValid = 1'b0;
   endtask

   task automatic checkInitSeq();
      for (int k = 0; k < 9; k++) begin
         logic [2:0] es;
         es = (k < 4) ? 3'd0 : (k < 7) ? 3'd1 : (k == 7) ? 3'd2 : 3'd3;
         checkOutput("init_state", state, es);
         checkOutput("init_din_valid", maDinValid, (k >= 1 && k <= 4));
         checkOutput("init_ma_rst", maRst, (k == 7));
         checkOutput("init_avg_valid", avgValid, 0);
         if (maDinValid) checkOutput("init_din_zero", maDin, 0);
         if (k < 8) @(negedge clk);
      end
      checkOutput("init_src_ready", srcReady, 1);
   endtask

   task automatic waitDrain();
      for (int n = 0; n < 40 && sbQ.size() != 0; n++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("drain_queue", sbQ.size(), 0);
   endtask

   task automatic waitState(input logic [2:0] target);
      for (int n = 0; n < 100 && state != target; n++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("wait_state", state, target);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      restart = 1'b0;
      enable = 1'b1;
      srcValid = 1'b0;
      srcData = '0;
      dpGarbage = 1'b1;
      injectValid = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      checkOutput("rst_state", state, 0);
      checkOutput("rst_src_ready", srcReady, 0);
      checkOutput("rst_ma_rst", maRst, 0);
      checkOutput("rst_din_valid", maDinValid, 0);
      checkOutput("rst_ma_din", maDin, 0);
      checkOutput("rst_avg", avg, 0);
      checkOutput("rst_avg_valid", avgValid, 0);
      checkOutput("rst_seq_err", seqErr, 0);

      // Init sequence, then 1..6 back-to-back: averages 3, 4, 5
      rst = 1'b0;
      dpGarbage = 1'b0;
      checkInitSeq();
      for (int v = 1; v <= 6; v++) applyStimulus(32'(v));
      waitDrain();
      checkOutput("run_state", state, 4);

      // Async reset mid-run with garbage preloaded into the BRAM, then -8 x4
      dpGarbage = 1'b1;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_state", state, 0);
      checkOutput("rst_mid_src_ready", srcReady, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      dpGarbage = 1'b0;
      checkInitSeq();
      for (int n = 0; n < 4; n++) applyStimulus(-32'sd8);
      waitDrain();

      // Restart in RUN with two samples in flight
      applyStimulus(32'sd100);
      applyStimulus(32'sd200);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      checkInitSeq();

      // Pause intake for 5 cycles mid-FILL
      applyStimulus(32'sd5);
      applyStimulus(32'sd7);
      enable = 1'b0;
      srcValid = 1'b1;
      srcData = 32'sd99;
      for (int n = 0; n < 5; n++) begin
         #1;
         checkOutput("pause_src_ready", srcReady, 0);
         checkOutput("pause_state", state, 3);
         @(negedge clk);
      end
      srcValid = 1'b0;
      enable = 1'b1;
      applyStimulus(32'sd9);
      applyStimulus(32'sd11);
      waitDrain();
      checkOutput("pause_run_state", state, 4);

      // Spurious datapath output during DRAIN
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      waitState(3'd1);
      checkOutput("pre_inject_seq_err", seqErr, 0);
      injectValid = 1'b1;
      @(negedge clk);
      injectValid = 1'b0;
      #1;
      checkOutput("inject_seq_err", seqErr, 1);
      checkOutput("inject_avg_valid", avgValid, 0);
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      #1;
      checkOutput("restart_seq_err", seqErr, 0);
      checkOutput("restart_state", state, 0);
      waitState(3'd3);
      repeat (5) @(negedge clk);
      checkOutput("final_seq_err", seqErr, 0);
      checkOutput("final_queue", sbQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
